// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder:
//   - write size codes (0 means a full 4-byte word)
//   - write-buffer entry layout {word index, lane mask, data}
//   - dm_lane_mask(): big-endian byte-lane enable for a write
// Lane numbering is big-endian: lane 0 = bits [31:24], lane 3 = bits [7:0].
// Mask bit i always covers data bits [8*i+7:8*i], so lane L maps to mask[3-L].
// -----------------------------------------------------------------------------
package dm_pkg;

   // Word-index field is sized for the widest possible array so the entry
   // type does not depend on the responder's ADDR_WIDTH; unused upper bits
   // are held at zero.
   localparam int DM_IDX_W = 30;

   typedef enum logic [1:0] {
      DM_SZ_WORD   = 2'd0,
      DM_SZ_BYTE   = 2'd1,
      DM_SZ_HALF   = 2'd2,
      DM_SZ_TRIPLE = 2'd3
   } dm_size_e;

   typedef struct packed {
      logic [DM_IDX_W-1:0] idx;
      logic [3:0]          mask;
      logic [31:0]         data;
   } dm_wb_entry_t;

   // Lanes addr_lo .. addr_lo+n-1 are enabled; anything past lane 3 is
   // clipped rather than wrapping into the next word.
   function automatic logic [3:0] dm_lane_mask(input logic [1:0] addr_lo,
                                               input logic [1:0] size);
      logic [3:0] m;
      int         n;
      int         lo;
      m  = '0;
      lo = int'(addr_lo);
      n  = (size == DM_SZ_WORD) ? 4 : int'(size);
      for (int l = 0; l < 4; l++) begin
         if (l >= lo && l < lo + n) begin
            m[3-l] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/dm_write_buffer.sv
// -----------------------------------------------------------------------------
// dm_write_buffer
// Small FIFO of posted writes with a parallel, newest-first forwarding lookup.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, entry_i    enqueue request and entry (ignored when full)
//   pop_i              dequeue oldest entry (ignored when empty)
//   head_o             oldest entry (valid when !empty_o)
//   full_o, empty_o    occupancy flags
//   lookup_idx_i       word index to forward for
//   fwd_hit_o          per-byte hit (bit i covers data bits [8i+7:8i])
//   fwd_data_o         forwarded bytes (valid where fwd_hit_o is set)
// -----------------------------------------------------------------------------
module dm_write_buffer
   import dm_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                push_i,
   input  dm_wb_entry_t        entry_i,
   input  logic                pop_i,
   output dm_wb_entry_t        head_o,
   output logic                full_o,
   output logic                empty_o,
   input  logic [DM_IDX_W-1:0] lookup_idx_i,
   output logic [3:0]          fwd_hit_o,
   output logic [31:0]         fwd_data_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   dm_wb_entry_t     entries_q [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign head_o  = entries_q[head_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) tail_q <= ptr_inc(tail_q);
         if (pop_ok)  head_q <= ptr_inc(head_q);
         if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
         else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
      end
   end

   // Entry payload needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (push_ok) entries_q[tail_q] <= entry_i;
   end

   // Walk from oldest to newest so later (newer) matches overwrite earlier
   // ones, giving newest-first priority per byte.
   always_comb begin
      fwd_hit_o  = '0;
      fwd_data_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         int           s;
         dm_wb_entry_t e;
         s = int'(head_q) + k;
         if (s >= DEPTH) s = s - DEPTH;
         e = entries_q[PTR_W'(s)];
         if (k < int'(count_q) && e.idx == lookup_idx_i) begin
            for (int i = 0; i < 4; i++) begin
               if (e.mask[i]) begin
                  fwd_hit_o[i]        = 1'b1;
                  fwd_data_o[8*i +: 8] = e.data[8*i +: 8];
               end
            end
         end
      end
   end

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Memory-side end of the MEM stage data port: word-aligned reads, byte-lane
// posted writes through a write buffer, drain into a single-port array.
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   data_address_2DM      byte address; [ADDR_WIDTH+1:2] word, [1:0] lane
//   data_write_2DM        write data, bytes already in lane position
//   data_write_size_2DM   byte count (0 = 4)
//   MemRead_2DM           read request
//   MemWrite_2DM          write request
//   data_read_fDM         combinational read data (0 when not reading)
//   DM_Stall_fDM          write refused this cycle (buffer full)
// -----------------------------------------------------------------------------
module dm_responder
   import dm_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int WB_DEPTH   = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] data_address_2DM,
   input  logic [31:0] data_write_2DM,
   input  logic [1:0]  data_write_size_2DM,
   input  logic        MemRead_2DM,
   input  logic        MemWrite_2DM,
   output logic [31:0] data_read_fDM,
   output logic        DM_Stall_fDM
);

   logic [31:0]           mem_q [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [3:0]            wr_mask;
   logic                  wb_full, wb_empty;
   logic                  push, pop;
   dm_wb_entry_t          push_entry, drain_entry;
   logic [ADDR_WIDTH-1:0] drain_idx;
   logic [3:0]            fwd_hit;
   logic [31:0]           fwd_data;
   logic [31:0]           arr_word;
   logic [31:0]           merged;
   logic                  unused_bits;

   assign word_idx = data_address_2DM[ADDR_WIDTH+1:2];
   assign wr_mask  = dm_lane_mask(data_address_2DM[1:0], data_write_size_2DM);

   assign DM_Stall_fDM = MemWrite_2DM && wb_full;
   assign push = MemWrite_2DM && !DM_Stall_fDM && (wr_mask != 4'b0000);
   // Drain only on an idle port, or when a stalled write forces room.
   assign pop  = !wb_empty && ((!MemRead_2DM && !MemWrite_2DM) || DM_Stall_fDM);

   assign push_entry = '{idx: DM_IDX_W'(word_idx), mask: wr_mask, data: data_write_2DM};

   dm_write_buffer #(
      .DEPTH(WB_DEPTH)
   ) u_wb (
      .clk_i        (CLK),
      .rst_ni       (RESET),
      .push_i       (push),
      .entry_i      (push_entry),
      .pop_i        (pop),
      .head_o       (drain_entry),
      .full_o       (wb_full),
      .empty_o      (wb_empty),
      .lookup_idx_i (DM_IDX_W'(word_idx)),
      .fwd_hit_o    (fwd_hit),
      .fwd_data_o   (fwd_data)
   );

   assign drain_idx = drain_entry.idx[ADDR_WIDTH-1:0];

   // Storage array: no reset, byte-lane writes on drain.
   always_ff @(posedge CLK) begin
      if (pop) begin
         for (int i = 0; i < 4; i++) begin
            if (drain_entry.mask[i]) begin
               mem_q[drain_idx][8*i +: 8] <= drain_entry.data[8*i +: 8];
            end
         end
      end
   end

   assign arr_word = mem_q[word_idx];

   // Read sees pre-enqueue state: this cycle's write lands in the buffer at
   // the edge, so it cannot forward to a read in the same cycle.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[8*gi +: 8] = fwd_hit[gi] ? fwd_data[8*gi +: 8]
                                                : arr_word[8*gi +: 8];
      end
   endgenerate

   assign data_read_fDM = (MemRead_2DM && RESET) ? merged : 32'h0;

   assign unused_bits = ^{data_address_2DM[31:ADDR_WIDTH+2],
                          drain_entry.idx[DM_IDX_W-1:ADDR_WIDTH]};

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// Directed test of dm_responder with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_dm_responder;

   logic        CLK;
   logic        RESET;
   logic [31:0] data_address_2DM;
   logic [31:0] data_write_2DM;
   logic [1:0]  data_write_size_2DM;
   logic        MemRead_2DM;
   logic        MemWrite_2DM;
   logic [31:0] data_read_fDM;
   logic        DM_Stall_fDM;

   int checks = 0;
   int errors = 0;

   dm_responder #(
      .ADDR_WIDTH (10),
      .WB_DEPTH   (2)
   ) dut (
      .CLK                 (CLK),
      .RESET               (RESET),
      .data_address_2DM    (data_address_2DM),
      .data_write_2DM      (data_write_2DM),
      .data_write_size_2DM (data_write_size_2DM),
      .MemRead_2DM         (MemRead_2DM),
      .MemWrite_2DM        (MemWrite_2DM),
      .data_read_fDM       (data_read_fDM),
      .DM_Stall_fDM        (DM_Stall_fDM)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_in(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] sz);
      MemRead_2DM         = rd;
      MemWrite_2DM        = wr;
      data_address_2DM    = a;
      data_write_2DM      = d;
      data_write_size_2DM = sz;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      $display("check %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      set_in(1'b0, 1'b1, a, d, sz);
      cyc();
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic exp_stall);
      set_in(1'b0, 1'b1, a, d, sz);
      chk(tag, {31'b0, DM_Stall_fDM}, {31'b0, exp_stall});
      cyc();
   endtask

   task automatic idle_cyc();
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      cyc();
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      set_in(1'b1, 1'b0, a, 32'h0, 2'd0);
      chk(tag, data_read_fDM, exp);
      cyc();
   endtask

   initial begin
      // Reset with read and write requested: outputs must stay quiet.
      RESET = 1'b0;
      set_in(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 2'd0);
      chk("rst_read", data_read_fDM, 32'h0);
      chk("rst_stall", {31'b0, DM_Stall_fDM}, 32'h0);
      repeat (2) cyc();
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      RESET = 1'b1;
      cyc();

      // Byte lanes and forwarding
      wr_cyc(32'h0, 32'h1122_3344, 2'd0);
      idle_cyc();
      rd_chk("init_w0", 32'h0, 32'h1122_3344);
      wr_cyc(32'h1, 32'hAAAA_AAAA, 2'd1);
      rd_chk("sb_fwd", 32'h0, 32'h11AA_3344);
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
      chk("idle_read_zero", data_read_fDM, 32'h0);
      cyc();
      rd_chk("sb_array", 32'h0, 32'h11AA_3344);

      // Clipping: word write at lane 2 touches lanes 2-3 only
      wr_cyc(32'h4, 32'h0, 2'd0);
      idle_cyc();
      wr_cyc(32'h6, 32'hDEAD_BEEF, 2'd0);
      rd_chk("clip_fwd", 32'h4, 32'h0000_BEEF);
      idle_cyc();
      rd_chk("clip_array", 32'h4, 32'h0000_BEEF);

      // Stall on third back-to-back write
      wr_chk("st_w1", 32'h10, 32'h1010_1010, 2'd0, 1'b0);
      wr_chk("st_w2", 32'h14, 32'h1414_1414, 2'd0, 1'b0);
      wr_chk("st_w3_stall", 32'h18, 32'h1818_1818, 2'd0, 1'b1);
      wr_chk("st_w3_accept", 32'h18, 32'h1818_1818, 2'd0, 1'b0);
      rd_chk("st_r10", 32'h10, 32'h1010_1010);
      rd_chk("st_r14", 32'h14, 32'h1414_1414);
      rd_chk("st_r18", 32'h18, 32'h1818_1818);
      idle_cyc();
      idle_cyc();
      rd_chk("st_r14_arr", 32'h14, 32'h1414_1414);
      rd_chk("st_r18_arr", 32'h18, 32'h1818_1818);

      // Forwarding priority: newer halfword overrides older word
      wr_cyc(32'h20, 32'h0102_0304, 2'd0);
      wr_cyc(32'h20, 32'hFFFF_0000, 2'd2);
      rd_chk("prio_fwd", 32'h20, 32'hFFFF_0304);
      idle_cyc();
      idle_cyc();
      rd_chk("prio_array", 32'h20, 32'hFFFF_0304);

      // Reset mid-operation
      wr_cyc(32'h40, 32'h1234_5678, 2'd0);
      idle_cyc();
      wr_cyc(32'h40, 32'hCAFE_F00D, 2'd0);
      wr_cyc(32'h44, 32'h0BAD_BEEF, 2'd0);
      set_in(1'b1, 1'b1, 32'h40, 32'h5555_5555, 2'd0);
      chk("pre_rst_full_stall", {31'b0, DM_Stall_fDM}, 32'h1);
      RESET = 1'b0;
      #1;
      chk("mid_rst_stall", {31'b0, DM_Stall_fDM}, 32'h0);
      chk("mid_rst_read", data_read_fDM, 32'h0);
      RESET = 1'b1;
      rd_chk("post_rst_array", 32'h40, 32'h1234_5678);
      wr_chk("post_rst_w1", 32'h48, 32'h4848_4848, 2'd0, 1'b0);
      wr_chk("post_rst_w2", 32'h4C, 32'h4C4C_4C4C, 2'd0, 1'b0);
      wr_chk("post_rst_w3_stall", 32'h50, 32'h5050_5050, 2'd0, 1'b1);
      wr_chk("post_rst_w3_accept", 32'h50, 32'h5050_5050, 2'd0, 1'b0);
      idle_cyc();
      idle_cyc();
      rd_chk("post_rst_r48", 32'h48, 32'h4848_4848);
      rd_chk("post_rst_r50", 32'h50, 32'h5050_5050);
      rd_chk("post_rst_r40", 32'h40, 32'h1234_5678);

      // Read and write in the same cycle
      wr_cyc(32'h30, 32'h1122_3344, 2'd0);
      idle_cyc();
      set_in(1'b1, 1'b1, 32'h30, 32'h9900_0000, 2'd1);
      chk("rmw_old", data_read_fDM, 32'h1122_3344);
      cyc();
      rd_chk("rmw_merged", 32'h30, 32'h9922_3344);
      idle_cyc();
      rd_chk("rmw_array", 32'h30, 32'h9922_3344);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
